data_memory: RTL

Block-organised data memory that sits directly downstream of the data cache and services its line fills and write-backs. It holds 64 blocks of 32 bits (256 bytes) addressed by a 6-bit block address. It models a fixed multi-cycle access latency behind a `busywait` handshake. It captures each request, stalls the requester for `LATENCY` cycles, then commits a write or returns a read word for one cycle.

---
 rtl/data_memory.sv | 85 ++++++++
 1 files changed

// File: rtl/data_memory.sv
// Block data memory behind the data cache: 64 x 32-bit words with a fixed
// multi-cycle access latency exposed through a busywait handshake.
module data_memory #(
  parameter int unsigned LATENCY = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read,
  input  logic        write,
  input  logic [5:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic [5:0]  req_addr;
  logic [31:0] req_data;
  logic        req_wr;
  logic        request;
  logic        commit;
  logic [31:0] mem [0:63];

  assign request = read | write;
  assign commit  = (state == BUSY) && (cnt == '0);

  // Gated by reset so the stall drops as soon as reset is asserted,
  // not only after the synchronous reset edge.
  assign busywait = reset && (((state == IDLE) && request) || (state == BUSY));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (request) next_state = BUSY;
      BUSY:    if (cnt == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt      <= '0;
      readdata <= '0;
    end else begin
      case (state)
        IDLE: if (request) cnt <= CNT_LOAD;
        BUSY: begin
          if (cnt != '0)   cnt <= cnt - 4'd1;
          else if (!req_wr) readdata <= mem[req_addr];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset && (state == IDLE) && request) begin
      req_addr <= address;
      req_data <= writedata;
      req_wr   <= write;
    end
  end

  // Storage is never cleared; a reset edge during BUSY suppresses the commit.
  always_ff @(posedge clock) begin
    if (reset && commit && req_wr) mem[req_addr] <= req_data;
  end

endmodule
